// File: rtl/sha3_pad.sv
// SHA3-512 input packer: 32-bit words into 576-bit rate blocks,
// with pad10*1 (domain 0x06) applied on the final beat.
module sha3_pad #(
  parameter int BITS = 32,
  parameter int RATE = 576
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  input  logic            in_last,
  input  logic [2:0]      in_bytes,
  output logic            in_ready,
  output logic            blk_valid,
  output logic [RATE-1:0] blk_data,
  output logic            blk_last,
  input  logic            blk_ready
);

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    PADBLK
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      wcnt_q, wcnt_d;
  logic [RATE-1:0] buf_q, buf_d;
  logic            rdy_q, rdy_d;
  logic            last_q, last_d;
  logic            pend_q, pend_d;

  logic [2:0]      nb;
  logic [6:0]      p;
  logic [BITS-1:0] wdat;
  logic            acc;
  logic            xfer;

  assign nb = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign p  = {wcnt_q, 2'b00} + {4'd0, nb};

  // Bytes past the valid count of a final beat are forced to zero
  always_comb begin
    wdat = in_data;
    for (int k = 0; k < 4; k++) begin
      if (in_last && (3'(k) >= nb)) begin
        wdat[8*k +: 8] = 8'h00;
      end
    end
  end

  assign blk_valid = (state_q != FILL);
  assign acc       = in_valid && rdy_q;
  assign xfer      = blk_valid && blk_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    buf_d   = buf_q;
    last_d  = last_q;
    pend_d  = pend_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          buf_d[{wcnt_q, 5'd0} +: BITS] = wdat;
          if (in_last) begin
            state_d = HOLD;
            if (p < 7'd72) begin
              buf_d[{p, 3'd0} +: 8] |= 8'h06;
              buf_d[RATE-1 -: 8]    |= 8'h80;
              last_d = 1'b1;
            end else begin
              last_d = 1'b0;
              pend_d = 1'b1;
            end
          end else begin
            wcnt_d = wcnt_q + 5'd1;
            if (wcnt_q == 5'd17) begin
              state_d = HOLD;
              last_d  = 1'b0;
            end
          end
        end
      end
      HOLD, PADBLK: begin
        if (xfer) begin
          buf_d  = '0;
          wcnt_d = '0;
          pend_d = 1'b0;
          if (pend_q) begin
            buf_d[7:0]         = 8'h06;
            buf_d[RATE-1 -: 8] = 8'h80;
            last_d  = 1'b1;
            state_d = PADBLK;
          end else begin
            last_d  = 1'b0;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign rdy_d = (state_d == FILL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      wcnt_q  <= '0;
      buf_q   <= '0;
      rdy_q   <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      buf_q   <= buf_d;
      rdy_q   <= rdy_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign in_ready = rdy_q;
  assign blk_data = buf_q;
  assign blk_last = last_q;

endmodule

// File: doc/sha3_pad.md
# sha3_pad

Input-side message packer and padder for the SHA3-512 datapath. Accepts the message as a stream of 32-bit little-endian words and packs them into 576-bit rate blocks (18 words). On the final word it applies SHA3 pad10*1 with domain byte 0x06. It presents each block with a valid/ready handshake to the absorb stage's 576-bit `data_in` input.

## Interface
- `BITS`, 32: input word width; fixed at 32, other values unsupported.
- `RATE`, 576: block width in bits; fixed at 576 (SHA3-512), 18 words / 72 bytes.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input word present.
- `in_data`  in  32: message word; byte k of the word is at bits [8k+7:8k].
- `in_last`  in  1: this beat ends the message.
- `in_bytes`  in  3: valid bytes in the last beat, 0..4. Ignored when `in_last`=0. Values above 4 are treated as 4.
- `in_ready`  out  1: block accepts a word this cycle.
- `blk_valid`  out  1: `blk_data` holds a complete block.
- `blk_data`  out  576: rate block. Word w is at [32w+31:32w]; byte b is at [8b+7:8b].
- `blk_last`  out  1: this block is the final block of the message.
- `blk_ready`  in  1: downstream accepts the block.

## Operation
- States:
  - FILL: accepting words.
  - HOLD: block presented.
  - PADBLK: pad-only block presented.
- Registers:
  - `wcnt` (5 bits, 0..17): next word slot.
  - 576-bit buffer.
  - `in_ready` flag.
- Reset (`reset_n` low, asynchronous):
  - state FILL, `wcnt`=0, buffer 0.
  - `in_ready`=0, `blk_valid`=0, `blk_last`=0, `blk_data`=0.
  - `in_ready` rises on the first clock edge after `reset_n` is released.
- Word transfer occurs on a rising edge with `in_valid && in_ready`.
- FILL, non-last word:
  - Write to slot `wcnt`; `wcnt`+1.
  - If slot 17 was written: go to HOLD with `blk_last`=0.
- FILL, last word with n=`in_bytes`:
  - Bytes 0..n-1 of `in_data` are stored. Unused input bytes are masked to 0.
  - Message byte index p = 4·`wcnt` + n.
  - If p<72: byte p |= 0x06, byte 71 |= 0x80, all bytes above p other than 71 are 0. Go to HOLD with `blk_last`=1.
  - If p=71: byte 71 = 0x86.
  - If p=72 (slot 17, n=4): go to HOLD with `blk_last`=0 and set a pending-pad flag.
- HOLD:
  - `blk_valid`=1, `in_ready`=0. `blk_data` and `blk_last` stay stable until transfer.
  - On `blk_valid && blk_ready`:
    - If pending-pad is set: load pad block (byte 0=0x06, byte 71=0x80, rest 0) and go to PADBLK with `blk_valid` staying 1 and `blk_last`=1.
    - Otherwise: clear buffer, `wcnt`=0, `blk_valid`=0, `blk_last`=0, go to FILL with `in_ready`=1.
- PADBLK: on transfer, clear the buffer and flag and go to FILL, same as the HOLD exit.
- `in_valid` is ignored whenever `in_ready`=0.
- A new message may start immediately after the last block transfers. No state carries over between messages.
- `in_last` with `in_bytes`=0 at `wcnt`=0 is the empty message.

## Timing
- One word per cycle is accepted in FILL.
- `blk_valid` asserts on the edge that accepts the 18th word or the last word. There is 0 cycles of added latency beyond the register stage.
- `in_ready` deasserts on that same edge.
- Block to next FILL: `in_ready`=1 in the cycle after the block transfer edge.
- Block to pad block: back-to-back, with no bubble on `blk_valid`.
- Minimum block period is 19 cycles (18 fill + 1 handshake) when `blk_ready` is held high.
- Reset asserted mid-message or mid-HOLD discards everything immediately, including a pending pad block. No partial block is ever emitted.

## Test plan
- Empty message: one beat with `in_last`=1, `in_bytes`=0 -> one block with byte 0=0x06, byte 71=0x80, all else 0, `blk_last`=1.
- "abc": `in_data`=0x00636261, `in_bytes`=3, `in_last`=1 -> bytes 0..3 = 61 62 63 06, byte 71=0x80, rest 0, `blk_last`=1.
- 71-byte message of 0xA5 (17 full words, then last beat with `in_bytes`=3) -> bytes 0..70 = 0xA5, byte 71=0x86, `blk_last`=1.
- 72-byte message (18 full words, last beat with `in_bytes`=4):
  - first block is all message data with `blk_last`=0;
  - the following cycle after transfer, the pad block appears (0x06 … 0x80) with `blk_last`=1, with no `blk_valid` gap;
  - `in_ready` returns 1 after the second transfer.
- Backpressure: hold `blk_ready`=0 for 10 cycles while driving `in_valid`=1 with changing data -> `blk_data` stable, `in_ready`=0, no words consumed. Releasing `blk_ready` gives a single transfer.
- Reset mid-fill: after 5 words, pulse `reset_n` low asynchronously (mid-cycle) -> all outputs 0 at once. After release, an empty message yields exactly the empty-message block, with no stale data.
